// File: rtl/gpi_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gpi_scan_pkg                                           |
// | Description : Shared types and constants for the GPI scan controller |
// |               (FSM state encoding, GPI register map, timer width).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package gpi_scan_pkg;

   // Width of the shared poll/timeout counter
   localparam int GPI_TMR_W = 16;

   // GPI slave register map
   localparam logic [2:0] GPI_CR_ADDR  = 3'b000;   // control (input enable)
   localparam logic [2:0] GPI_IDR_ADDR = 3'b100;   // input data

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_CFG_SETUP  = 3'd1,
      ST_CFG_ACCESS = 3'd2,
      ST_WAIT       = 3'd3,
      ST_RD_SETUP   = 3'd4,
      ST_RD_ACCESS  = 3'd5
   } gpi_state_t;

endpackage
`default_nettype wire

// File: rtl/gpi_poll_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gpi_poll_timer                                         |
// | Description : Load / decrement down-counter with a zero flag. The    |
// |               count saturates at zero.                               |
// | Revision    : 1.0 - initial release                                  |
// | Ports       : PCLK, PRESET  clock / async active-high reset          |
// |               load, load_val  synchronous load of a start value      |
// |               dec             decrement enable (ignored at zero)     |
// |               zero            high while the count equals zero       |
// +----------------------------------------------------------------------+
module gpi_poll_timer
   import gpi_scan_pkg::*;
#(
   parameter int WIDTH = GPI_TMR_W
)(
   input  logic             PCLK,
   input  logic             PRESET,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gpi_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gpi_scan_ctrl                                          |
// | Description : APB master that configures a GPI slave once, then      |
// |               polls its input data register, tracking toggled bits   |
// |               and raising irq on any change.                         |
// | Revision    : 1.0 - initial release                                  |
// | Ports       : PCLK, PRESET      clock / async active-high reset      |
// |               PSEL, PENABLE, PWRITE, PADDR, PWDATA  APB master out   |
// |               PRDATA, PREADY    APB slave response                   |
// |               en                scan enable                          |
// |               irq_clr           one-cycle clear of irq / chg / err   |
// |               gpi_val           last sampled input value             |
// |               chg               sticky mask of toggled bits          |
// |               irq, err, busy    change pending / timeout / active    |
// +----------------------------------------------------------------------+
module gpi_scan_ctrl
   import gpi_scan_pkg::*;
#(
   parameter int         POLL_DIV = 1000,
   parameter logic [7:0] CR_INIT  = 8'hFF,
   parameter int         TO_CYC   = 16
)(
   input  logic        PCLK,
   input  logic        PRESET,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [2:0]  PADDR,
   output logic [31:0] PWDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        en,
   input  logic        irq_clr,
   output logic [7:0]  gpi_val,
   output logic [7:0]  chg,
   output logic        irq,
   output logic        err,
   output logic        busy
);

   localparam logic [GPI_TMR_W-1:0] c_wait_ld = GPI_TMR_W'(POLL_DIV - 1);
   localparam logic [GPI_TMR_W-1:0] c_to_ld   = GPI_TMR_W'(TO_CYC - 1);

   gpi_state_t             r_state;
   gpi_state_t             w_state_nxt;
   logic                   r_cfg_done;
   logic                   r_prime;
   logic                   w_cfg_ok;
   logic                   w_rd_done;
   logic                   w_timeout;
   logic [7:0]             w_delta;
   logic                   w_tmr_load;
   logic [GPI_TMR_W-1:0]   w_tmr_val;
   logic                   w_tmr_zero;
   logic                   w_unused_prdata;

   // Only the low byte of the data register carries inputs
   assign w_unused_prdata = ^PRDATA[31:8];

   // ------------------------------------------------------------------
   // Next-state decode
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cfg_ok    = 1'b0;
      w_rd_done   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (en) w_state_nxt = r_cfg_done ? ST_RD_SETUP : ST_CFG_SETUP;
         end
         ST_CFG_SETUP: w_state_nxt = ST_CFG_ACCESS;
         ST_CFG_ACCESS: begin
            if (PREADY) begin
               w_cfg_ok    = 1'b1;
               w_state_nxt = en ? ST_RD_SETUP : ST_IDLE;
            end else if (w_tmr_zero) begin
               w_timeout   = 1'b1;
               w_state_nxt = en ? ST_WAIT : ST_IDLE;
            end
         end
         ST_RD_SETUP: w_state_nxt = ST_RD_ACCESS;
         ST_RD_ACCESS: begin
            if (PREADY) begin
               w_rd_done   = 1'b1;
               w_state_nxt = en ? ST_WAIT : ST_IDLE;
            end else if (w_tmr_zero) begin
               w_timeout   = 1'b1;
               w_state_nxt = en ? ST_WAIT : ST_IDLE;
            end
         end
         ST_WAIT: begin
            // A failed configuration is retried on the next poll
            if (!en)             w_state_nxt = ST_IDLE;
            else if (w_tmr_zero) w_state_nxt = r_cfg_done ? ST_RD_SETUP : ST_CFG_SETUP;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // First read after configuration only establishes the baseline
   assign w_delta = (w_rd_done && !r_prime) ? (PRDATA[7:0] ^ gpi_val) : 8'h00;

   // One counter serves both phases: the timeout count is armed while in
   // SETUP, the poll delay on every entry into WAIT.
   assign w_tmr_load = (r_state == ST_CFG_SETUP) || (r_state == ST_RD_SETUP) ||
                       ((w_state_nxt == ST_WAIT) && (r_state != ST_WAIT));
   assign w_tmr_val  = (w_state_nxt == ST_WAIT) ? c_wait_ld : c_to_ld;

   gpi_poll_timer #(
      .WIDTH    (GPI_TMR_W)
   ) u_timer (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .dec      (1'b1),
      .zero     (w_tmr_zero)
   );

   // ------------------------------------------------------------------
   // State and registered outputs; APB signals are decoded from the
   // next state so they line up with the state they describe.
   // ------------------------------------------------------------------
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state    <= ST_IDLE;
         r_cfg_done <= 1'b0;
         r_prime    <= 1'b1;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         PADDR      <= 3'b000;
         PWDATA     <= 32'h0;
         gpi_val    <= 8'h00;
         chg        <= 8'h00;
         irq        <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         busy    <= (w_state_nxt != ST_IDLE);

         PSEL    <= 1'b0;
         PENABLE <= 1'b0;
         PWRITE  <= 1'b0;
         PADDR   <= 3'b000;
         PWDATA  <= 32'h0;
         case (w_state_nxt)
            ST_CFG_SETUP, ST_CFG_ACCESS: begin
               PSEL    <= 1'b1;
               PENABLE <= (w_state_nxt == ST_CFG_ACCESS);
               PWRITE  <= 1'b1;
               PADDR   <= GPI_CR_ADDR;
               PWDATA  <= {24'h0, CR_INIT};
            end
            ST_RD_SETUP, ST_RD_ACCESS: begin
               PSEL    <= 1'b1;
               PENABLE <= (w_state_nxt == ST_RD_ACCESS);
               PADDR   <= GPI_IDR_ADDR;
            end
            default: ;
         endcase

         if (w_cfg_ok) begin
            r_cfg_done <= 1'b1;
            r_prime    <= 1'b1;
         end
         if (w_rd_done) begin
            gpi_val <= PRDATA[7:0];
            r_prime <= 1'b0;
         end

         // A change arriving with the clear survives it
         chg <= (irq_clr ? 8'h00 : chg) | w_delta;
         irq <= (irq_clr ? 1'b0 : irq) | (w_delta != 8'h00);
         err <= (irq_clr ? 1'b0 : err) | w_timeout;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gpi_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_gpi_scan_ctrl                                       |
// | Description : Self-checking bench for gpi_scan_ctrl with a simple    |
// |               GPI slave model (controllable PREADY).                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_gpi_scan_ctrl;

   logic        PCLK;
   logic        PRESET;
   logic        PSEL, PENABLE, PWRITE;
   logic [2:0]  PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY;
   logic        en, irq_clr;
   logic [7:0]  gpi_val, chg;
   logic        irq, err, busy;

   logic [7:0]  gpi;
   logic        ready_en;
   int          cyc;
   int          t_done;
   int          n_chk;
   int          n_err;

   typedef struct {
      logic [7:0] gpi;
      logic       clr;
      logic [7:0] exp_val;
      logic [7:0] exp_chg;
      logic       exp_irq;
   } vec_t;

   vec_t vecs[8];

   // GPI slave: zero-wait-state when ready_en is set, stalls otherwise
   assign PREADY = PSEL & PENABLE & ready_en;
   assign PRDATA = {24'h0, gpi};

   gpi_scan_ctrl #(
      .POLL_DIV (4),
      .CR_INIT  (8'hFF),
      .TO_CYC   (16)
   ) dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PWRITE   (PWRITE),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .en       (en),
      .irq_clr  (irq_clr),
      .gpi_val  (gpi_val),
      .chg      (chg),
      .irq      (irq),
      .err      (err),
      .busy     (busy)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_chk++;
      n_err++;
      $display("FAIL %s: wait budget expired", nm);
   endtask

   // Wait until a SETUP phase is on the bus (sampled on negedge)
   task automatic wait_setup(input string nm);
      int n = 0;
      while (!(PSEL && !PENABLE) && n < 200) begin
         @(negedge PCLK);
         n++;
      end
      if (n >= 200) bound_fail(nm);
   endtask

   // Wait for a read completion, optionally pulsing irq_clr in that cycle
   task automatic wait_done(input string nm, input logic clr);
      int n = 0;
      while (!(PSEL && PENABLE && PREADY && !PWRITE) && n < 200) begin
         @(negedge PCLK);
         n++;
      end
      if (n >= 200) begin
         bound_fail(nm);
      end else begin
         irq_clr = clr;
         @(posedge PCLK);
         #1;
         irq_clr = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acc;

      cyc      = 0;
      n_chk    = 0;
      n_err    = 0;
      PRESET   = 1'b1;
      en       = 1'b0;
      irq_clr  = 1'b0;
      gpi      = 8'h00;
      ready_en = 1'b1;

      //        gpi    clr   gpi_val chg    irq
      vecs[0] = '{8'h05, 1'b0, 8'h05, 8'h05, 1'b1};
      vecs[1] = '{8'h85, 1'b1, 8'h85, 8'h80, 1'b1};
      vecs[2] = '{8'h85, 1'b1, 8'h85, 8'h00, 1'b0};
      vecs[3] = '{8'h85, 1'b0, 8'h85, 8'h00, 1'b0};
      vecs[4] = '{8'hF0, 1'b0, 8'hF0, 8'h75, 1'b1};
      vecs[5] = '{8'h0F, 1'b0, 8'h0F, 8'hFF, 1'b1};
      vecs[6] = '{8'h0F, 1'b1, 8'h0F, 8'h00, 1'b0};
      vecs[7] = '{8'h00, 1'b0, 8'h00, 8'h0F, 1'b1};

      // ---------------- reset state ----------------
      @(negedge PCLK);
      chk("rst_ctl",  32'({PSEL, PENABLE, PWRITE, PADDR}), 32'h0);
      chk("rst_wdat", PWDATA, 32'h0);
      chk("rst_stat", 32'({gpi_val, chg, irq, err, busy}), 32'h0);

      // ---------------- configuration write + first read ----------------
      PRESET = 1'b0;
      en     = 1'b1;
      n = 0;
      while (!(PSEL && PENABLE && PREADY && PWRITE) && n < 200) begin
         @(negedge PCLK);
         n++;
      end
      if (n >= 200) bound_fail("cfg_wait");
      chk("cfg_addr",  32'(PADDR), 32'h0);
      chk("cfg_wdata", PWDATA, 32'h000000FF);
      @(negedge PCLK);
      wait_setup("rd0_setup");
      chk("rd0_ctl", 32'({PWRITE, PADDR}), 32'({1'b0, 3'b100}));
      wait_done("rd0_done", 1'b0);
      chk("rd0_val", 32'(gpi_val), 32'h00);
      chk("rd0_irq", 32'({chg, irq}), 32'h0);
      chk("rd0_busy", 32'(busy), 32'h1);
      t_done = cyc;

      // ---------------- polling vectors ----------------
      for (int i = 0; i < 8; i++) begin
         gpi = vecs[i].gpi;
         if (i == 0) begin
            wait_setup("gap_setup");
            chk("poll_gap", 32'(cyc - t_done), 32'd4);
         end
         wait_done($sformatf("vec%0d_done", i), vecs[i].clr);
         chk($sformatf("vec%0d_val", i), 32'(gpi_val), 32'(vecs[i].exp_val));
         chk($sformatf("vec%0d_chg", i), 32'(chg),     32'(vecs[i].exp_chg));
         chk($sformatf("vec%0d_irq", i), 32'(irq),     32'(vecs[i].exp_irq));
      end

      // ---------------- clear, then en=0 during RD_ACCESS ----------------
      @(negedge PCLK);
      irq_clr = 1'b1;
      @(posedge PCLK);
      #1;
      irq_clr = 1'b0;
      chk("clr_only", 32'({chg, irq}), 32'h0);
      ready_en = 1'b0;
      n = 0;
      while (!(PSEL && PENABLE && !PWRITE) && n < 200) begin
         @(negedge PCLK);
         n++;
      end
      if (n >= 200) bound_fail("en0_access");
      en = 1'b0;
      @(negedge PCLK);
      chk("en0_held", 32'({PSEL, PENABLE}), 32'h3);
      ready_en = 1'b1;
      @(posedge PCLK);
      #1;
      chk("en0_idle", 32'({busy, PSEL}), 32'h0);
      repeat (3) @(negedge PCLK);
      chk("en0_stay", 32'(busy), 32'h0);
      en = 1'b1;
      @(posedge PCLK);
      #1;
      chk("en1_rdsetup", 32'({PSEL, PENABLE, PWRITE, PADDR}), 32'({3'b100, 3'b100}));
      wait_done("en1_done", 1'b0);
      chk("en1_nochg", 32'({chg, irq}), 32'h0);

      // ---------------- CFG timeout and retry ----------------
      @(negedge PCLK);
      PRESET   = 1'b1;
      ready_en = 1'b0;
      @(negedge PCLK);
      PRESET = 1'b0;
      acc = 0;
      n   = 0;
      while (n < 100) begin
         @(negedge PCLK);
         n++;
         if (PSEL && PENABLE) acc++;
         else if (acc > 0) break;
      end
      if (n >= 100) bound_fail("to_wait");
      chk("to_cycles", 32'(acc), 32'd16);
      chk("to_err",    32'({err, PSEL}), 32'h2);
      wait_setup("retry_setup");
      chk("retry_cfg", 32'({PWRITE, PADDR}), 32'({1'b1, 3'b000}));

      // ---------------- async reset in CFG_ACCESS ----------------
      n = 0;
      while (!(PSEL && PENABLE) && n < 50) begin
         @(negedge PCLK);
         n++;
      end
      if (n >= 50) bound_fail("cfgacc_wait");
      #2;
      PRESET = 1'b1;
      #1;
      chk("arst_ctl",  32'({PSEL, PENABLE, PWRITE, PADDR}), 32'h0);
      chk("arst_wdat", PWDATA, 32'h0);
      chk("arst_stat", 32'({err, busy}), 32'h0);
      gpi      = 8'h05;
      ready_en = 1'b1;
      @(negedge PCLK);
      PRESET = 1'b0;
      @(negedge PCLK);
      wait_setup("restart_setup");
      chk("restart_cfg", 32'({PWRITE, PADDR}), 32'({1'b1, 3'b000}));
      wait_done("restart_done", 1'b0);
      chk("prime_val", 32'(gpi_val), 32'h05);
      chk("prime_chg", 32'({chg, irq}), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gpi_scan_ctrl.md
GPI_SCAN_CTRL -- requirements
Module: gpi_scan_ctrl

Interface
REQ-001 Parameter POLL_DIV, default 1000, PCLK cycles from the end of one poll to the next read SETUP; legal range 2..65535.
REQ-002 Parameter CR_INIT, default 8'hFF, input-enable mask written to the GPI control register.
REQ-003 Parameter TO_CYC, default 16, maximum ACCESS-phase cycles to wait for PREADY.
REQ-004 PCLK  in  1  clock; PRESET  in  1  reset, asynchronous, active-high.
REQ-005 PSEL, PENABLE, PWRITE  out  1 each  APB master controls toward the GPI slave.
REQ-006 PADDR  out  3  APB address; PWDATA  out  32  write data.
REQ-007 PRDATA  in  32  read data; PREADY  in  1  transfer complete.
REQ-008 en  in  1  scan enable; irq_clr  in  1  one-cycle clear of irq, chg and err.
REQ-009 gpi_val  out  8  last sampled input value; chg  out  8  sticky mask of toggled bits.
REQ-010 irq  out  1  change pending; err  out  1  sticky PREADY timeout; busy  out  1  high whenever state != IDLE.

Function
REQ-011 States: IDLE, CFG_SETUP, CFG_ACCESS, WAIT, RD_SETUP, RD_ACCESS.
REQ-012 IDLE->CFG_SETUP when en=1 and cfg_done=0; IDLE->RD_SETUP when en=1 and cfg_done=1.
REQ-013 CFG_SETUP (1 cycle): PSEL=1, PENABLE=0, PWRITE=1, PADDR=3'b000, PWDATA={24'b0,CR_INIT}; then CFG_ACCESS.
REQ-014 CFG_ACCESS: same signals with PENABLE=1, held until PREADY=1; on PREADY set cfg_done and prime, go to RD_SETUP.
REQ-015 RD_SETUP (1 cycle): PSEL=1, PENABLE=0, PWRITE=0, PADDR=3'b100; then RD_ACCESS.
REQ-016 RD_ACCESS: PENABLE=1 until PREADY=1; on PREADY gpi_val<=PRDATA[7:0], go to WAIT (or IDLE if en=0).
REQ-017 delta = PRDATA[7:0] ^ gpi_val, masked to 0 when prime=1; prime clears after the read completes.
REQ-018 chg <= (irq_clr ? 8'h00 : chg) | delta; irq <= (irq_clr ? 0 : irq) | (delta != 0); a simultaneous change wins over the clear.
REQ-019 WAIT loads timer with POLL_DIV-1 on entry, decrements each cycle, enters RD_SETUP on the cycle after it reads 0; with en=0 it goes to IDLE instead.
REQ-020 ACCESS timeout: once TO_CYC cycles have elapsed in an ACCESS state without PREADY, drop PSEL/PENABLE, set err, go to WAIT; a CFG timeout leaves cfg_done=0, so the next poll reattempts CFG_SETUP.
REQ-021 en=0 never aborts an APB transfer: the transfer completes (or times out), then the FSM goes to IDLE.
REQ-022 Outside SETUP/ACCESS states: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0.
REQ-023 APB outputs are registered; there is no combinational path from PREADY/PRDATA to any output.

Reset
REQ-024 PRESET forces IDLE, cfg_done=0, prime=1, timer=0, gpi_val=0, chg=0, irq=0, err=0, busy=0, and all APB outputs to 0, asserting mid-transfer without waiting for PREADY.

Structure
REQ-025 The shared package gpi_scan_pkg holds the state enum, GPI_CR_ADDR=3'b000, GPI_IDR_ADDR=3'b100, and the timer width constant (16).
REQ-026 One sub-module, gpi_poll_timer, is the load/decrement/zero-flag counter; it is reused for the WAIT delay and the ACCESS timeout counter.

Verification
REQ-027 Reset, en=1, GPI slave attached, gpi=8'h00 -> write of 32'h000000FF to addr 0, then read of addr 4; irq=0, gpi_val=8'h00.
REQ-028 POLL_DIV=4, gpi steps 8'h00->8'h05 between polls -> next read gives gpi_val=8'h05, chg=8'h05, irq=1; read SETUP occurs exactly 4 cycles after the previous PREADY.
REQ-029 irq=1, chg=8'h05, irq_clr pulses in the same cycle a read returns a toggle of bit 7 -> chg=8'h80, irq=1.
REQ-030 Slave PREADY tied 0 -> after 16 ACCESS cycles PSEL drops and err=1; the next poll retries CFG_SETUP.
REQ-031 en=0 during RD_ACCESS -> transfer completes on PREADY, FSM enters IDLE, busy=0; with en=1 again the next transfer is RD_SETUP with no change flagged.
REQ-032 PRESET asserted in CFG_ACCESS -> all outputs 0 immediately; after release plus en=1, the block restarts with CFG_SETUP.
